// File: rtl/tinyenc_arb_if.sv
// Client and core signal bundle for tinyenc_arb.
// The err signal exists only when TINYENC_ARB_TIMEOUT_EN is defined.
interface tinyenc_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   wdata;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic [31:0]          rdata;
  logic                 busy;
  logic                 core_req;
  logic [31:0]          core_wdata;
  logic                 core_ack;
  logic [31:0]          core_rdata;
`ifdef TINYENC_ARB_TIMEOUT_EN
  logic                 err;

  modport slave (
    input  req, wdata, core_ack, core_rdata,
    output grant, done, rdata, busy, core_req, core_wdata, err
  );

  modport master (
    output req, wdata, core_ack, core_rdata,
    input  grant, done, rdata, busy, core_req, core_wdata, err
  );
`else
  modport slave (
    input  req, wdata, core_ack, core_rdata,
    output grant, done, rdata, busy, core_req, core_wdata
  );

  modport master (
    output req, wdata, core_ack, core_rdata,
    input  grant, done, rdata, busy, core_req, core_wdata
  );
`endif
endinterface

// File: rtl/tinyenc_arb.sv
// Round-robin arbiter/sequencer sharing one tinyenc core between NREQ clients.
// Optional ISSUE+BUSY abort timer enabled by defining TINYENC_ARB_TIMEOUT_EN.
module tinyenc_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rstb,
  tinyenc_arb_if.slave  io_bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  state_t            r_state, w_stateNext;
  logic [PW-1:0]     r_ptr, w_ptrNext;
  logic [PW-1:0]     r_sel, w_selNext;
  logic [PW-1:0]     w_pick, w_idx;
  logic              w_found;
  logic [NREQ-1:0]   r_grant, w_grantNext;
  logic [NREQ-1:0]   r_done, w_doneNext;
  logic [31:0]       r_rdata, w_rdataNext;
  logic [31:0]       r_coreWdata, w_coreWdataNext;
  logic              r_coreReq, w_coreReqNext;
  logic              w_timeout;

`ifdef TINYENC_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  logic [CW-1:0]     r_cnt, w_cntNext;
  logic              r_err, w_errNext;

  // Abort on the edge where the counter would reach TIMEOUT.
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
  assign io_bus.err = r_err;
`else
  assign w_timeout  = 1'b0;
`endif

  // Lowest offset from ptr wins, so scan offsets high to low and keep the last hit.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (io_bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_found) w_stateNext = ISSUE;
      ISSUE:   if (w_timeout) w_stateNext = DONE;
               else if (!io_bus.core_ack) w_stateNext = BUSY;
      BUSY:    if (io_bus.core_ack || w_timeout) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_ptrNext       = r_ptr;
    w_selNext       = r_sel;
    w_grantNext     = r_grant;
    w_doneNext      = r_done;
    w_rdataNext     = r_rdata;
    w_coreWdataNext = r_coreWdata;
    w_coreReqNext   = r_coreReq;
`ifdef TINYENC_ARB_TIMEOUT_EN
    w_cntNext       = r_cnt;
    w_errNext       = r_err;
    if (r_state == ISSUE || r_state == BUSY) w_cntNext = r_cnt + 1'b1;
`endif
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_selNext       = w_pick;
          w_grantNext     = NREQ'(1) << w_pick;
          w_coreWdataNext = io_bus.wdata[32*w_pick +: 32];
          w_coreReqNext   = 1'b1;
`ifdef TINYENC_ARB_TIMEOUT_EN
          w_cntNext       = '0;
`endif
        end
      end
      ISSUE, BUSY: begin
        if (r_state == BUSY && io_bus.core_ack) begin
          w_rdataNext = io_bus.core_rdata;
          w_doneNext  = r_grant;
        end else if (w_timeout) begin
          w_coreReqNext = 1'b0;
          w_rdataNext   = '0;
          w_doneNext    = r_grant;
`ifdef TINYENC_ARB_TIMEOUT_EN
          w_errNext     = 1'b1;
`endif
        end else if (r_state == ISSUE && !io_bus.core_ack) begin
          w_coreReqNext = 1'b0;
        end
      end
      DONE: begin
        w_doneNext  = '0;
        w_grantNext = '0;
        w_ptrNext   = (r_sel == PW'(NREQ - 1)) ? '0 : r_sel + 1'b1;
`ifdef TINYENC_ARB_TIMEOUT_EN
        w_errNext   = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_ptr       <= '0;
      r_sel       <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_coreWdata <= '0;
      r_coreReq   <= 1'b0;
`ifdef TINYENC_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_ptr       <= w_ptrNext;
      r_sel       <= w_selNext;
      r_grant     <= w_grantNext;
      r_done      <= w_doneNext;
      r_rdata     <= w_rdataNext;
      r_coreWdata <= w_coreWdataNext;
      r_coreReq   <= w_coreReqNext;
`ifdef TINYENC_ARB_TIMEOUT_EN
      r_cnt       <= w_cntNext;
      r_err       <= w_errNext;
`endif
    end
  end

  assign io_bus.grant      = r_grant;
  assign io_bus.done       = r_done;
  assign io_bus.rdata      = r_rdata;
  assign io_bus.busy       = (r_state != IDLE);
  assign io_bus.core_req   = r_coreReq;
  assign io_bus.core_wdata = r_coreWdata;
endmodule

// File: tb/tb_tinyenc_arb.sv
// Directed bench for tinyenc_arb with a behavioural tinyenc core (ROUND rounds, TEA-style on 16-bit halves).
// Define TINYENC_ARB_TIMEOUT_EN to also exercise the abort timer with TIMEOUT = 20.
module tb_tinyenc_arb;
  localparam int NREQ  = 4;
  localparam int ROUND = 5;
`ifdef TINYENC_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 20;
`else
  localparam int TB_TIMEOUT = 1023;
`endif
  localparam logic [15:0] DELTA = 16'h79B9;
  localparam logic [15:0] K0 = 16'h0123, K1 = 16'h4567, K2 = 16'h89AB, K3 = 16'hCDEF;

  logic clk = 1'b0;
  logic rstb;
  int   compared;
  int   mismatched;

  logic [31:0] W [4];
  logic [NREQ-1:0] reqMask;

  // Behavioural core state
  logic        coreAck   = 1'b1;
  logic [31:0] coreRdata = '0;
  logic [31:0] coreResult = '0;
  int          coreCnt   = 0;
  int          stallCnt  = 0;
  int          stallCycles = 0;
  logic        tieHigh   = 1'b0;

  tinyenc_arb_if #(.NREQ(NREQ)) bus ();

  tinyenc_arb #(.NREQ(NREQ), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk    (clk),
    .rstb   (rstb),
    .io_bus (bus.slave)
  );

  assign bus.core_ack   = coreAck;
  assign bus.core_rdata = coreRdata;

  always #5 clk = ~clk;

  function automatic logic [31:0] teaModel(input logic [31:0] pt);
    logic [15:0] v0, v1, sum;
    v0  = pt[15:0];
    v1  = pt[31:16];
    sum = '0;
    for (int r = 0; r < ROUND; r++) begin
      sum = sum + DELTA;
      v0  = v0 + (((v1 << 4) + K0) ^ (v1 + sum) ^ ((v1 >> 5) + K1));
      v1  = v1 + (((v0 << 4) + K2) ^ (v0 + sum) ^ ((v0 >> 5) + K3));
    end
    return {v1, v0};
  endfunction

  // Core accepts a request while idle (after optional stall), drops ack, then
  // raises ack with the result ROUND edges later.
  always @(posedge clk) begin
    if (coreCnt > 0) begin
      if (coreCnt == 1) begin
        coreAck   <= 1'b1;
        coreRdata <= coreResult;
      end
      coreCnt <= coreCnt - 1;
    end else if (coreAck && bus.core_req && !tieHigh) begin
      if (stallCnt < stallCycles) begin
        stallCnt <= stallCnt + 1;
      end else begin
        stallCnt   <= 0;
        coreAck    <= 1'b0;
        coreCnt    <= ROUND;
        coreResult <= teaModel(bus.core_wdata);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r);
    reqMask = r;
    bus.req = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    W[0] = 32'h12345678;
    W[1] = 32'hDEADBEEF;
    W[2] = 32'h0BADF00D;
    W[3] = 32'hCAFEBABE;
    bus.wdata = {W[3], W[2], W[1], W[0]};
    applyStimulus('0);
    rstb = 1'b0;
    tick(3);
    checkOutput("rst_grant", 32'(bus.grant), 32'h0);
    checkOutput("rst_done", 32'(bus.done), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_core_req", 32'(bus.core_req), 32'h0);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    rstb = 1'b1;
    tick(1);

    $display("[TB] single client");
    applyStimulus(4'b0001);
    tick(1);
    checkOutput("s_core_req", 32'(bus.core_req), 32'h1);
    checkOutput("s_grant", 32'(bus.grant), 32'h1);
    checkOutput("s_core_wdata", bus.core_wdata, W[0]);
    checkOutput("s_busy", 32'(bus.busy), 32'h1);
    tick(1);
    checkOutput("s_req_held", 32'(bus.core_req), 32'h1);
    tick(1);
    checkOutput("s_req_drop", 32'(bus.core_req), 32'h0);
    tick(4);
    checkOutput("s_done_early", 32'(bus.done), 32'h0);
    tick(1);
    checkOutput("s_done", 32'(bus.done), 32'h1);
    checkOutput("s_rdata", bus.rdata, teaModel(W[0]));
    applyStimulus('0);
    tick(1);
    checkOutput("s_done_clr", 32'(bus.done), 32'h0);
    checkOutput("s_grant_clr", 32'(bus.grant), 32'h0);
    checkOutput("s_idle", 32'(bus.busy), 32'h0);

    rstb = 1'b0;
    tick(2);
    rstb = 1'b1;
    tick(1);

    $display("[TB] all clients");
    applyStimulus(4'b1111);
    tick(1);
    for (int n = 0; n < NREQ; n++) begin
      checkOutput($sformatf("rr_grant%0d", n), 32'(bus.grant), 32'(1) << n);
      tick(6);
      checkOutput($sformatf("rr_early%0d", n), 32'(bus.done), 32'h0);
      tick(1);
      checkOutput($sformatf("rr_done%0d", n), 32'(bus.done), 32'(1) << n);
      checkOutput($sformatf("rr_rdata%0d", n), bus.rdata, teaModel(W[n]));
      applyStimulus(reqMask & ~(NREQ'(1) << n));
      tick(2);
    end
    checkOutput("rr_end_grant", 32'(bus.grant), 32'h0);
    checkOutput("rr_end_busy", 32'(bus.busy), 32'h0);

    $display("[TB] pointer skip");
    applyStimulus(4'b0010);
    tick(1);
    checkOutput("p_grant1", 32'(bus.grant), 32'h2);
    tick(7);
    checkOutput("p_done1", 32'(bus.done), 32'h2);
    applyStimulus(4'b0011);
    tick(2);
    checkOutput("p_grant0", 32'(bus.grant), 32'h1);
    tick(7);
    checkOutput("p_done0", 32'(bus.done), 32'h1);
    checkOutput("p_rdata0", bus.rdata, teaModel(W[0]));
    applyStimulus(4'b0010);
    tick(2);
    checkOutput("p_regrant1", 32'(bus.grant), 32'h2);
    tick(7);
    checkOutput("p_redone1", 32'(bus.done), 32'h2);
    checkOutput("p_rdata1", bus.rdata, teaModel(W[1]));
    applyStimulus('0);
    tick(2);

    $display("[TB] stalled core");
    stallCycles = 6;
    applyStimulus(4'b0100);
    tick(1);
    checkOutput("st_grant", 32'(bus.grant), 32'h4);
    tick(7);
    checkOutput("st_req_held", 32'(bus.core_req), 32'h1);
    checkOutput("st_wdata_held", bus.core_wdata, W[2]);
    tick(1);
    checkOutput("st_req_drop", 32'(bus.core_req), 32'h0);
    tick(4);
    checkOutput("st_done_early", 32'(bus.done), 32'h0);
    tick(1);
    checkOutput("st_done", 32'(bus.done), 32'h4);
    checkOutput("st_rdata", bus.rdata, teaModel(W[2]));
    stallCycles = 0;
    applyStimulus('0);
    tick(2);

    $display("[TB] reset mid-transaction");
    applyStimulus(4'b0001);
    tick(1);
    checkOutput("r_grant", 32'(bus.grant), 32'h1);
    tick(3);
    rstb = 1'b0;
    #1;
    checkOutput("r_grant0", 32'(bus.grant), 32'h0);
    checkOutput("r_busy0", 32'(bus.busy), 32'h0);
    checkOutput("r_core_req0", 32'(bus.core_req), 32'h0);
    checkOutput("r_rdata0", bus.rdata, 32'h0);
    checkOutput("r_wdata0", bus.core_wdata, 32'h0);
    applyStimulus('0);
    tick(2);
    rstb = 1'b1;
    tick(8);
    checkOutput("r_no_done", 32'(bus.done), 32'h0);
    applyStimulus(4'b1000);
    tick(1);
    checkOutput("r_grant3", 32'(bus.grant), 32'h8);
    tick(7);
    checkOutput("r_done3", 32'(bus.done), 32'h8);
    checkOutput("r_rdata3", bus.rdata, teaModel(W[3]));
    applyStimulus('0);
    tick(2);

`ifdef TINYENC_ARB_TIMEOUT_EN
    $display("[TB] timeout");
    tieHigh = 1'b1;
    applyStimulus(4'b0011);
    tick(1);
    checkOutput("t_grant0", 32'(bus.grant), 32'h1);
    tick(TB_TIMEOUT - 1);
    checkOutput("t_done_early", 32'(bus.done), 32'h0);
    checkOutput("t_req_held", 32'(bus.core_req), 32'h1);
    tick(1);
    checkOutput("t_done", 32'(bus.done), 32'h1);
    checkOutput("t_err", 32'(bus.err), 32'h1);
    checkOutput("t_rdata", bus.rdata, 32'h0);
    checkOutput("t_req_drop", 32'(bus.core_req), 32'h0);
    tieHigh = 1'b0;
    applyStimulus(4'b0010);
    tick(2);
    checkOutput("t_next_grant", 32'(bus.grant), 32'h2);
    tick(7);
    checkOutput("t_next_done", 32'(bus.done), 32'h2);
    checkOutput("t_next_err", 32'(bus.err), 32'h0);
    checkOutput("t_next_rdata", bus.rdata, teaModel(W[1]));
    applyStimulus('0);
    tick(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
